// File: rtl/char_feed_pkg.sv
// Shared definitions for the character-feed controller.
//   state_e : frame sequencer states
//   FILLER  : zero-symbol idle byte (symbol-count field 6), safe to feed the
//             decoder at any time without producing output symbols
package char_feed_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [7:0] FILLER = 8'hC0;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is visible on rd_data
// combinationally; a write into an empty FIFO shows up the following cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : write strobe and data (dropped when full)
//   rd_en           : pop the head entry (ignored when empty)
//   rd_data         : current head entry
//   full, empty     : status
//   level           : occupancy, 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [Aw:0]      level
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == (Aw+1)'(Depth));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write to a full FIFO is dropped even when a pop happens in the same cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/char_feed_ctrl.sv
// Sequencing controller for the character decoder. Buffers host bytes in a
// show-ahead FIFO and feeds one frame of `len` bytes to the decoder over a
// req/next handshake, substituting FILLER on underrun and while draining.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_data           : host byte write
//   start, len, abort        : frame control (start ignored while busy)
//   dec_req, dec_pdata       : request and byte presented to the decoder
//   dec_next                 : decoder consumes dec_pdata this cycle
//   busy, done               : frame in progress / one-cycle end pulse
//   fifo_full/empty/level    : FIFO status
//   overflow                 : sticky, write arrived while full
//   underrun_cnt             : saturating count of mid-frame filler consumes
module char_feed_ctrl
  import char_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = 8,
  localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic            abort,
  output logic            dec_req,
  output logic [7:0]      dec_pdata,
  input  logic            dec_next,
  output logic            busy,
  output logic            done,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic [LvlW-1:0] fifo_level,
  output logic            overflow,
  output logic [7:0]      underrun_cnt
);

  state_e        state_q;
  logic [LW-1:0] remaining_q;
  logic          done_q;
  logic          overflow_q;
  logic [7:0]    underrun_q;
  logic [7:0]    head;
  logic          pop;

  sync_fifo #(
    .Width (8),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Only real bytes are popped; filler consumes leave the FIFO untouched.
  assign pop = (state_q == StRun) && !fifo_empty && dec_next;

  assign dec_req      = (state_q != StIdle);
  assign dec_pdata    = (state_q == StRun && !fifo_empty) ? head : FILLER;
  // busy covers the done cycle so a start coinciding with done is ignored.
  assign busy         = (state_q != StIdle) || done_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign underrun_cnt = underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !busy) begin
            remaining_q <= len;
            overflow_q  <= 1'b0;
            underrun_q  <= '0;
            state_q     <= (len != '0) ? StRun : StDrain;
          end
        end
        StRun: begin
          if (dec_next) begin
            if (!fifo_empty) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == LW'(1)) begin
                state_q <= StDrain;
              end
            end else if (underrun_q != 8'hFF) begin
              underrun_q <= underrun_q + 1'b1;
            end
          end
          // The consume in the abort cycle above is still honoured.
          if (abort) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // One filler consume lets the decoder finish the last real symbol.
          if (dec_next) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A dropped write in the start cycle still leaves the flag set.
      if (wr_en && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/char_feed_ctrl.md
# char_feed_ctrl

Sequencing controller for the character decoder. Buffers encoded character bytes from a host-side write port and runs one frame of a programmed byte count: it drives the decoder's request line, presents the next byte, and retires each byte on the decoder's `next` handshake. Mid-frame underruns and frame end are filled with a zero-symbol idle byte, so the decoder never freezes mid-symbol.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, at least 2.
- `LW`, 8: width of the frame-length field.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host byte write strobe.
- `wr_data`  in  8  encoded character byte.
- `start`  in  1  start-frame pulse; ignored while `busy`.
- `len`  in  LW  number of bytes in the frame, sampled on accepted `start`.
- `abort`  in  1  end the frame early.
- `dec_req`  out  1  request to decoder.
- `dec_pdata`  out  8  byte presented to decoder.
- `dec_next`  in  1  decoder consumes `dec_pdata` this cycle; only meaningful while `dec_req`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle end-of-frame pulse.
- `fifo_full`, `fifo_empty`  out  1  FIFO status.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: a write arrived while the FIFO was full.
- `underrun_cnt`  out  8  saturating count of filler bytes inserted mid-frame.

## Operation
- FIFO: show-ahead; head byte is visible combinationally.
  - A write when full is dropped and sets `overflow`.
  - A write and pop in the same cycle are both honoured.
  - A write into an empty FIFO becomes visible in the next cycle (no bypass).
- FILLER = 8'hC0 (symbol-count field 6). The decoder consumes it, emits no symbols and returns to its idle count.
- States:
  - IDLE: `dec_req`=0, `dec_pdata`=FILLER. An accepted `start` loads `remaining`=`len` and clears `overflow` and `underrun_cnt`.
    - `len`≠0: go to RUN.
    - `len`=0: go to DRAIN.
  - RUN: `dec_req`=1.
    - FIFO non-empty: `dec_pdata`=head. On `dec_next`, pop the FIFO and decrement `remaining`. If `remaining` was 1, go to DRAIN.
    - FIFO empty: `dec_pdata`=FILLER. On `dec_next`, increment `underrun_cnt` (saturating at 255); `remaining` is unchanged.
  - DRAIN: `dec_req`=1, `dec_pdata`=FILLER. On `dec_next`, go to IDLE and pulse `done`. This waits out the symbols of the last real byte.
- `abort` in RUN: from the next cycle, behave as DRAIN and stop popping. In the abort cycle itself, a consume is still honoured.
- `abort` in IDLE or DRAIN: no effect.
- Unconsumed FIFO bytes remain for the next frame.
- `busy` = (state≠IDLE) or `done`.

## Timing
- Reset values:
  - State IDLE; FIFO empty; `remaining`=0.
  - `dec_req`=0, `dec_pdata`=8'hC0, `busy`=0, `done`=0.
  - `fifo_full`=0, `fifo_empty`=1, `fifo_level`=0, `overflow`=0, `underrun_cnt`=0.
- Reset mid-frame: everything returns to the reset values in the next cycle; FIFO contents are discarded. The decoder must be reset in the same cycle.
- `start` to `dec_req`=1: one cycle.
- Byte transfer: a byte is transferred exactly in the cycles where `dec_req` and `dec_next` are both 1.
  - The decoder asserts `dec_next` in the first `dec_req` cycle after its reset.
  - After that, it asserts `dec_next` one cycle after finishing its last symbol.
- `done` is registered: asserted in the cycle after the DRAIN consume, together with state=IDLE. `busy` stays high through that cycle.
- `start` in the same cycle as `done`: ignored.
- `dec_req`, `dec_pdata`, `busy`: combinational from state and FIFO head. `done` and all flags: registered.

## Structure
- Package `char_feed_pkg`: state enum (IDLE, RUN, DRAIN), constant FILLER = 8'hC0.
- Sub-module `sync_fifo`: show-ahead FIFO parameterized by width and depth, with full/empty/level outputs.
- Top level holds the FSM, `remaining`, the counters and the flags.

## Test plan
- Write 8'h45, 8'hA3; `start` with `len`=2.
  - Frames observed on `dec_next` cycles: 8'h45, 8'hA3, then 8'hC0.
  - `done` one cycle after the FILLER consume; `underrun_cnt`=0; FIFO empty.
- `start` with `len`=3 and one byte queued, with the decoder model asserting `dec_next` every cycle once the queued byte is consumed.
  - FILLER is presented while the FIFO is empty; `underrun_cnt` counts each consumed filler.
  - Writing two more bytes completes the frame; `done` fires once.
- `start` with `len`=0: DRAIN, then a FILLER consume, then `done`. No FIFO pop.
- Queue 5 bytes; `start` with `len`=5; assert `abort` after 2 consumes.
  - Next consume is FILLER, then `done`.
  - `fifo_level` reads 3 for the unconsumed bytes.
- Write 9 bytes with `DEPTH`=8: the ninth is dropped; `overflow`=1 and `fifo_full`=1. The next `start` clears `overflow`.
- Assert `rst` mid-RUN: next cycle `dec_req`=0, `fifo_level`=0, `busy`=0. `start` is ignored while `busy`.
